// File: rtl/rom_reader_if.sv
// Bus between the ROM reader and the logic around it: playback control,
// the ROM address/data pair and the registered word with its strobe.
interface rom_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              done;

  // Reader side: owns the address, the captured word and the status flags.
  modport slave (
    input  start, stop, loop_en, rom_data,
    output rom_addr, data_out, data_valid, busy, done
  );

  // Controller / ROM side: drives control and ROM data, observes the reader.
  modport master (
    output start, stop, loop_en, rom_data,
    input  rom_addr, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/rom_reader.sv
// Steps a combinational ROM through addresses 0..END_ADDR, holding each
// address for CLK_DIV cycles, then registers the word and strobes data_valid
// for one cycle. Single-pass or looping playback with start/stop control.
module rom_reader #(
  parameter int CLK_DIV  = 12_000_000,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int END_ADDR = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_reader_if.slave  bus
);
  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(END_ADDR);

  logic [1:0]        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;

  // Next-state logic; stop overrides everything, including a sample edge.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    data_s  = data_r;
    valid_s = 1'b0;
    if (bus.stop) begin
      state_s = ST_IDLE;
      cnt_s   = {CNT_W{1'b0}};
      addr_s  = {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_s = ST_RUN;
            cnt_s   = {CNT_W{1'b0}};
            addr_s  = {ADDR_W{1'b0}};
          end else begin
            state_s = state_r;
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            data_s  = bus.rom_data;
            valid_s = 1'b1;
            if (addr_r < ADDR_END) begin
              addr_s = addr_r + ADDR_W'(1);
            end else if (bus.loop_en) begin
              addr_s = {ADDR_W{1'b0}};
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
          addr_s  = {ADDR_W{1'b0}};
        end
      endcase
    end
    busy_s = (state_s == ST_RUN);
    done_s = (state_s == ST_DONE);
  end

  // State and output registers; reset aborts any run and drops pending strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.rom_addr   = addr_r;
  assign bus.data_out   = data_r;
  assign bus.data_valid = valid_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with CLK_DIV=4 and ROM word = {addr, ~addr}.
module tb_rom_reader;
  localparam int CLK_DIV = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  rom_reader_if #(.ADDR_W(4), .DATA_W(8)) rif ();

  assign rif.rom_data = {rif.rom_addr, ~rif.rom_addr};

  rom_reader #(.CLK_DIV(CLK_DIV), .ADDR_W(4), .DATA_W(8), .END_ADDR(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] word(input int a);
    logic [3:0] x;
    x = a[3:0];
    return {x, ~x};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    rif.start = 1'b1;
    step(1);
    rif.start = 1'b0;
  endtask

  task automatic pulse_stop();
    rif.stop = 1'b1;
    step(1);
    rif.stop = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (rif.rom_addr !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", rif.rom_addr); end
    checks++; if (rif.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rif.data_out); end
    checks++; if ({rif.data_valid, rif.busy, rif.done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rif.data_valid, rif.busy, rif.done}); end
    rst_n = 1'b1;
    step(6);
    checks++; if ({rif.data_valid, rif.busy} !== 2'b00) begin errors++; $display("FAIL idle_quiet: got %b expected 00", {rif.data_valid, rif.busy}); end
  endtask

  task automatic test_single_pass();
    rif.loop_en = 1'b0;
    pulse_start();
    checks++; if (rif.busy !== 1'b1) begin errors++; $display("FAIL sp_busy: got %b expected 1", rif.busy); end
    for (int k = 0; k < 16; k++) begin
      step(CLK_DIV - 1);
      checks++; if (rif.data_valid !== 1'b0) begin errors++; $display("FAIL sp_gap%0d: got %b expected 0", k, rif.data_valid); end
      step(1);
      checks++; if (rif.data_valid !== 1'b1) begin errors++; $display("FAIL sp_valid%0d: got %b expected 1", k, rif.data_valid); end
      checks++; if (rif.data_out !== word(k)) begin errors++; $display("FAIL sp_data%0d: got %h expected %h", k, rif.data_out, word(k)); end
    end
    checks++; if ({rif.done, rif.busy} !== 2'b10) begin errors++; $display("FAIL sp_done: got %b expected 10", {rif.done, rif.busy}); end
    checks++; if (rif.rom_addr !== 4'hF) begin errors++; $display("FAIL sp_end_addr: got %h expected f", rif.rom_addr); end
    step(1);
    checks++; if (rif.data_valid !== 1'b0) begin errors++; $display("FAIL sp_strobe_len: got %b expected 0", rif.data_valid); end
    step(8);
    checks++; if ({rif.done, rif.data_valid, rif.rom_addr} !== {1'b1, 1'b0, 4'hF}) begin errors++; $display("FAIL sp_hold: got %b expected 101111", {rif.done, rif.data_valid, rif.rom_addr}); end
  endtask

  task automatic test_start_from_done();
    pulse_start();
    checks++; if ({rif.done, rif.busy, rif.rom_addr} !== {1'b0, 1'b1, 4'h0}) begin errors++; $display("FAIL restart_state: got %b expected 010000", {rif.done, rif.busy, rif.rom_addr}); end
    step(CLK_DIV);
    checks++; if ({rif.data_valid, rif.data_out} !== {1'b1, 8'h0F}) begin errors++; $display("FAIL restart_data: got %h expected 10f", {rif.data_valid, rif.data_out}); end
    pulse_stop();
  endtask

  task automatic test_loop();
    rif.loop_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      step(CLK_DIV - 1);
      checks++; if (rif.data_valid !== 1'b0) begin errors++; $display("FAIL loop_gap%0d: got %b expected 0", k, rif.data_valid); end
      step(1);
      checks++; if ({rif.data_valid, rif.data_out} !== {1'b1, word(k)}) begin errors++; $display("FAIL loop_data%0d: got %h expected %h", k, {rif.data_valid, rif.data_out}, {1'b1, word(k)}); end
      checks++; if (rif.done !== 1'b0) begin errors++; $display("FAIL loop_done%0d: got %b expected 0", k, rif.done); end
    end
    pulse_stop();
    rif.loop_en = 1'b0;
  endtask

  task automatic test_stop_mid_run();
    pulse_start();
    step(3 * CLK_DIV + CLK_DIV - 1);
    checks++; if ({rif.rom_addr, rif.data_out} !== {4'h3, 8'h2D}) begin errors++; $display("FAIL stop_pre: got %h expected 32d", {rif.rom_addr, rif.data_out}); end
    pulse_stop();
    checks++; if (rif.data_valid !== 1'b0) begin errors++; $display("FAIL stop_strobe: got %b expected 0", rif.data_valid); end
    checks++; if (rif.data_out !== 8'h2D) begin errors++; $display("FAIL stop_data: got %h expected 2d", rif.data_out); end
    checks++; if ({rif.rom_addr, rif.busy} !== {4'h0, 1'b0}) begin errors++; $display("FAIL stop_state: got %b expected 00000", {rif.rom_addr, rif.busy}); end
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++; if (rif.data_valid !== 1'b0) begin errors++; $display("FAIL stop_quiet%0d: got %b expected 0", i, rif.data_valid); end
    end
  endtask

  task automatic test_contention();
    pulse_start();
    step(7 * CLK_DIV);
    checks++; if (rif.rom_addr !== 4'h7) begin errors++; $display("FAIL cont_addr7: got %h expected 7", rif.rom_addr); end
    pulse_start();
    step(CLK_DIV - 1);
    checks++; if ({rif.data_valid, rif.data_out} !== {1'b1, 8'h78}) begin errors++; $display("FAIL cont_word7: got %h expected 178", {rif.data_valid, rif.data_out}); end
    step(CLK_DIV);
    checks++; if ({rif.data_valid, rif.data_out, rif.rom_addr} !== {1'b1, 8'h87, 4'h9}) begin errors++; $display("FAIL cont_word8: got %h expected 1879", {rif.data_valid, rif.data_out, rif.rom_addr}); end
    pulse_stop();
    rif.start = 1'b1;
    rif.stop  = 1'b1;
    step(1);
    rif.start = 1'b0;
    rif.stop  = 1'b0;
    checks++; if ({rif.busy, rif.done} !== 2'b00) begin errors++; $display("FAIL both_idle: got %b expected 00", {rif.busy, rif.done}); end
    step(2 * CLK_DIV);
    checks++; if ({rif.busy, rif.data_valid} !== 2'b00) begin errors++; $display("FAIL both_quiet: got %b expected 00", {rif.busy, rif.data_valid}); end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    step(5 * CLK_DIV + 2);
    checks++; if ({rif.rom_addr, rif.busy} !== {4'h5, 1'b1}) begin errors++; $display("FAIL rst_pre: got %b expected 01011", {rif.rom_addr, rif.busy}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rif.rom_addr, rif.data_out} !== 12'h000) begin errors++; $display("FAIL rst_async_regs: got %h expected 000", {rif.rom_addr, rif.data_out}); end
    checks++; if ({rif.data_valid, rif.busy, rif.done} !== 3'b000) begin errors++; $display("FAIL rst_async_flags: got %b expected 000", {rif.data_valid, rif.busy, rif.done}); end
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++; if ({rif.data_valid, rif.busy} !== 2'b00) begin errors++; $display("FAIL rst_quiet%0d: got %b expected 00", i, {rif.data_valid, rif.busy}); end
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    rif.start   = 1'b0;
    rif.stop    = 1'b0;
    rif.loop_en = 1'b0;
    test_reset();
    test_single_pass();
    test_start_from_done();
    test_loop();
    test_stop_mid_run();
    test_contention();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
